// File: rtl/mem_arbiter.sv
// Memory-side arbiter: serialises instruction fetches and data accesses onto one
// single-ported RAM, data first, with a bounded wait that aborts a hung RAM access.
module mem_arbiter #(
    parameter int          MAX_WAIT = 16,
    parameter logic [31:0] BAD_WORD = 32'hBAD1BAD1
) (
    input  logic        CLK,
    input  logic        RST,
    input  logic        imemREN,
    input  logic [31:0] imemaddr,
    input  logic        dmemREN,
    input  logic        dmemWEN,
    input  logic [31:0] dmemaddr,
    input  logic [31:0] dmemstore,
    output logic        ihit,
    output logic [31:0] iload,
    output logic        dhit,
    output logic [31:0] dload,
    output logic        ramREN,
    output logic        ramWEN,
    output logic [31:0] ramaddr,
    output logic [31:0] ramstore,
    input  logic [31:0] ramload,
    input  logic        ram_ready,
    output logic        err,
    output logic [2:0]  dbg_state
);
    localparam int            CW         = $clog2(MAX_WAIT + 1);
    localparam logic [CW-1:0] WAIT_LIMIT = CW'(MAX_WAIT);

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        DREQ  = 3'd1,
        IREQ  = 3'd2,
        DRESP = 3'd3,
        IRESP = 3'd4
    } state_t;

    state_t        state_q, state_d;
    logic [CW-1:0] wait_q, wait_d;
    logic          wr_q, wr_d;
    logic          err_q, err_d;
    logic [31:0]   ramaddr_q, ramaddr_d;
    logic [31:0]   ramstore_q, ramstore_d;
    logic [31:0]   iload_q, iload_d;
    logic [31:0]   dload_q, dload_d;

    // Requests are levels sampled only in IDLE; the requester holds them until it
    // sees the one-cycle hit and drops them the following cycle. ram_ready is a
    // per-cycle completion only meaningful while a RAM strobe is up.
    always_comb begin
        state_d    = state_q;
        wait_d     = wait_q;
        wr_d       = wr_q;
        err_d      = err_q;
        ramaddr_d  = ramaddr_q;
        ramstore_d = ramstore_q;
        iload_d    = iload_q;
        dload_d    = dload_q;

        case (state_q)
            IDLE: begin
                wait_d = '0;
                if (dmemWEN || dmemREN) begin
                    ramaddr_d  = dmemaddr & 32'hFFFF_FFFC;
                    ramstore_d = dmemstore;
                    wr_d       = dmemWEN;
                    state_d    = DREQ;
                end else if (imemREN) begin
                    ramaddr_d = imemaddr & 32'hFFFF_FFFC;
                    wr_d      = 1'b0;
                    state_d   = IREQ;
                end
            end
            DREQ: begin
                if (ram_ready) begin
                    if (!wr_q) dload_d = ramload;
                    state_d = DRESP;
                end else if (wait_q == WAIT_LIMIT) begin
                    if (!wr_q) dload_d = BAD_WORD;
                    err_d   = 1'b1;
                    state_d = DRESP;
                end else begin
                    wait_d = wait_q + 1'b1;
                end
            end
            IREQ: begin
                if (ram_ready) begin
                    iload_d = ramload;
                    state_d = IRESP;
                end else if (wait_q == WAIT_LIMIT) begin
                    iload_d = BAD_WORD;
                    err_d   = 1'b1;
                    state_d = IRESP;
                end else begin
                    wait_d = wait_q + 1'b1;
                end
            end
            DRESP:   state_d = IDLE;
            IRESP:   state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q    <= IDLE;
            wait_q     <= '0;
            wr_q       <= 1'b0;
            err_q      <= 1'b0;
            ramaddr_q  <= '0;
            ramstore_q <= '0;
            iload_q    <= '0;
            dload_q    <= '0;
        end else begin
            state_q    <= state_d;
            wait_q     <= wait_d;
            wr_q       <= wr_d;
            err_q      <= err_d;
            ramaddr_q  <= ramaddr_d;
            ramstore_q <= ramstore_d;
            iload_q    <= iload_d;
            dload_q    <= dload_d;
        end
    end

    // Strobes and hits are pure state decodes so they can never overlap.
    assign ramREN    = (state_q == IREQ) || ((state_q == DREQ) && !wr_q);
    assign ramWEN    = (state_q == DREQ) && wr_q;
    assign ihit      = (state_q == IRESP);
    assign dhit      = (state_q == DRESP);
    assign ramaddr   = ramaddr_q;
    assign ramstore  = ramstore_q;
    assign iload     = iload_q;
    assign dload     = dload_q;
    assign err       = err_q;
    assign dbg_state = state_q;

endmodule
